// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
package regfile_wb_arbiter_pkg;

  localparam int unsigned RF_AW            = 5;
  localparam int unsigned RF_DW            = 32;
  localparam int unsigned STARVE_LIMIT_DEF = 4;
  // Wide enough for the largest legal starvation limit (15).
  localparam int unsigned CNT_W            = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FORCE = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic [RF_AW-1:0] wa;
    logic [RF_DW-1:0] wd;
  } wb_entry_t;

endpackage

// File: rtl/regfile_wb_arbiter_wb_fifo2.sv
// Two-entry FIFO buffering multicycle-unit writebacks.
module wb_fifo2
  import regfile_wb_arbiter_pkg::*;
(
  input  logic      clk,
  input  logic      rst_n,
  input  logic      push,
  input  wb_entry_t din,
  input  logic      pop,
  output wb_entry_t dout,
  output logic      full,
  output logic      empty
);

  wb_entry_t  mem [2];
  logic       wr_ptr;
  logic       rd_ptr;
  logic [1:0] count;
  logic       do_push;
  logic       do_pop;

  // A push into a full FIFO is refused even when a pop frees a slot that edge.
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign full    = (count == 2'd2);
  assign empty   = (count == 2'd0);
  assign dout    = mem[rd_ptr];

  // Pointer and occupancy bookkeeping; reset discards any buffered entries.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= ~wr_ptr;
      if (do_pop)  rd_ptr <= ~rd_ptr;
      case ({do_push, do_pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // Entry storage needs no reset; occupancy alone marks validity.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Arbitrates the register-file write port between the pipeline (A) and a
// buffered multicycle unit (B), with a busy scoreboard and anti-starvation stall.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             a_we,
  input  logic [RF_AW-1:0] a_wa,
  input  logic [RF_DW-1:0] a_wd,
  input  logic             b_valid,
  input  logic [RF_AW-1:0] b_wa,
  input  logic [RF_DW-1:0] b_wd,
  output logic             b_ready,
  input  logic             b_issue,
  input  logic [RF_AW-1:0] b_issue_wa,
  input  logic [RF_AW-1:0] ra1,
  input  logic [RF_AW-1:0] ra2,
  output logic             haz1,
  output logic             haz2,
  output logic             stall_pipe,
  output logic             rf_we,
  output logic [RF_AW-1:0] rf_wa,
  output logic [RF_DW-1:0] rf_wd
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT - 1);

  arb_state_t       state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic [31:0]      busy, busy_nx;
  wb_entry_t        head;
  logic             full, empty;
  logic             push, pop, a_sel;
  logic             drains_empty;

  wb_fifo2 u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .din   ('{wa: b_wa, wd: b_wd}),
    .pop   (pop),
    .dout  (head),
    .full  (full),
    .empty (empty)
  );

  assign b_ready = !full;
  assign push    = b_valid && !full;
  assign a_sel   = a_we && (a_wa != '0) && !stall_pipe;
  // A pop on a non-full FIFO leaves it empty unless a push lands the same edge.
  assign drains_empty = !full && !push;

  // Write-port mux: pipeline first, otherwise drain the FIFO head.
  always_comb begin
    rf_we = 1'b0;
    rf_wa = '0;
    rf_wd = '0;
    pop   = 1'b0;
    if (a_sel) begin
      rf_we = 1'b1;
      rf_wa = a_wa;
      rf_wd = a_wd;
    end else if (!empty) begin
      pop = 1'b1;
      if (head.wa != '0) begin
        rf_we = 1'b1;
        rf_wa = head.wa;
        rf_wd = head.wd;
      end
    end
  end

  // Starvation FSM next state and wait counter.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    case (state)
      ST_IDLE: begin
        cnt_nx = '0;
        if (push) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (pop) begin
          cnt_nx = '0;
          if (drains_empty) state_nx = ST_IDLE;
        end else if (cnt == CNT_MAX) begin
          cnt_nx   = '0;
          state_nx = ST_FORCE;
        end else begin
          cnt_nx = cnt + 1'b1;
        end
      end
      ST_FORCE: begin
        cnt_nx   = '0;
        state_nx = drains_empty ? ST_IDLE : ST_WAIT;
      end
      default: begin
        cnt_nx   = '0;
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Scoreboard update: a same-cycle issue to the popped address keeps it busy.
  always_comb begin
    busy_nx = busy;
    if (pop && (head.wa != '0)) busy_nx[head.wa] = 1'b0;
    if (b_issue && (b_issue_wa != '0)) busy_nx[b_issue_wa] = 1'b1;
  end

  // State, counter, stall flag and scoreboard registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      stall_pipe <= 1'b0;
      busy       <= '0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      stall_pipe <= (state_nx == ST_FORCE);
      busy       <= busy_nx;
    end
  end

  assign haz1 = busy[ra1] && (ra1 != '0);
  assign haz2 = busy[ra2] && (ra2 != '0);

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int L = 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        a_we;
  logic [4:0]  a_wa;
  logic [31:0] a_wd;
  logic        b_valid;
  logic [4:0]  b_wa;
  logic [31:0] b_wd;
  logic        b_ready;
  logic        b_issue;
  logic [4:0]  b_issue_wa;
  logic [4:0]  ra1, ra2;
  logic        haz1, haz2, stall_pipe, rf_we;
  logic [4:0]  rf_wa;
  logic [31:0] rf_wd;

  regfile_wb_arbiter #(.STARVE_LIMIT(L)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_we(a_we), .a_wa(a_wa), .a_wd(a_wd),
    .b_valid(b_valid), .b_wa(b_wa), .b_wd(b_wd), .b_ready(b_ready),
    .b_issue(b_issue), .b_issue_wa(b_issue_wa),
    .ra1(ra1), .ra2(ra2), .haz1(haz1), .haz2(haz2),
    .stall_pipe(stall_pipe),
    .rf_we(rf_we), .rf_wa(rf_wa), .rf_wd(rf_wd)
  );

  always #5 clk = ~clk;

  // Behavioural model state
  typedef struct {
    logic [4:0]  wa;
    logic [31:0] wd;
  } ent_t;
  ent_t q[$];
  bit   busy_m[32];
  bit   m_stall;
  int   starve;

  int passed = 0;
  int total  = 0;

  task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, got, exp, $time);
    else passed++;
  endtask

  task automatic model_clear();
    q.delete();
    foreach (busy_m[i]) busy_m[i] = 0;
    m_stall = 0;
    starve  = 0;
  endtask

  task automatic idle_in();
    a_we = 0; a_wa = 0; a_wd = 0;
    b_valid = 0; b_wa = 0; b_wd = 0;
    b_issue = 0; b_issue_wa = 0;
    ra1 = 0; ra2 = 0;
  endtask

  // Check every output against the model, then advance one clock.
  task automatic tick();
    bit          asel, pop, e_we, do_push;
    logic [4:0]  e_wa, h_wa;
    logic [31:0] e_wd;
    int          pre;
    #1;
    asel = a_we && (a_wa != 0) && !m_stall;
    pop  = 0; e_we = 0; e_wa = 0; e_wd = 0; h_wa = 0;
    if (asel) begin
      e_we = 1; e_wa = a_wa; e_wd = a_wd;
    end else if (q.size() > 0) begin
      pop  = 1;
      h_wa = q[0].wa;
      if (q[0].wa != 0) begin
        e_we = 1; e_wa = q[0].wa; e_wd = q[0].wd;
      end
    end
    cmp("rf_we", rf_we, e_we);
    cmp("rf_wa", rf_wa, e_wa);
    cmp("rf_wd", rf_wd, e_wd);
    cmp("b_ready", b_ready, q.size() < 2);
    cmp("stall_pipe", stall_pipe, m_stall);
    cmp("haz1", haz1, (ra1 != 0) && busy_m[ra1]);
    cmp("haz2", haz2, (ra2 != 0) && busy_m[ra2]);
    @(posedge clk);
    pre     = q.size();
    do_push = b_valid && (pre < 2);
    if (pop) begin
      void'(q.pop_front());
      if (h_wa != 0) busy_m[h_wa] = 0;
    end
    if (b_issue && b_issue_wa != 0) busy_m[b_issue_wa] = 1;
    if (do_push) q.push_back('{wa: b_wa, wd: b_wd});
    if (m_stall) begin
      m_stall = 0; starve = 0;
    end else if (pop) begin
      starve = 0;
    end else if (pre > 0) begin
      starve++;
      if (starve == L) begin
        m_stall = 1; starve = 0;
      end
    end
    @(negedge clk);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must clear at once.
  task automatic do_reset();
    a_we = 0; b_valid = 0; b_issue = 0;
    rst_n = 0;
    #1;
    cmp("rst_stall", stall_pipe, 1'b0);
    cmp("rst_b_ready", b_ready, 1'b1);
    cmp("rst_rf_we", rf_we, 1'b0);
    cmp("rst_haz1", haz1, 1'b0);
    cmp("rst_haz2", haz2, 1'b0);
    model_clear();
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1;
    idle_in();
    model_clear();
    @(negedge clk);
    do_reset();

    // B write clears its scoreboard bit after landing
    idle_in(); b_issue = 1; b_issue_wa = 5; tick();
    idle_in(); b_valid = 1; b_wa = 5; b_wd = 32'hDEADBEEF; ra1 = 5;
    #1 cmp("lit_haz1_5_set", haz1, 1'b1);
    tick();
    idle_in(); ra1 = 5;
    #1;
    cmp("lit_b_we", rf_we, 1'b1);
    cmp("lit_b_wa", rf_wa, 5'd5);
    cmp("lit_b_wd", rf_wd, 32'hDEADBEEF);
    tick();
    idle_in(); ra1 = 5;
    #1 cmp("lit_haz1_5_clr", haz1, 1'b0);
    tick();

    // Hazard window around issue and writeback of r9
    idle_in(); b_issue = 1; b_issue_wa = 9; ra1 = 9;
    #1 cmp("lit_haz1_nobypass", haz1, 1'b0);
    tick();
    idle_in(); ra1 = 9; b_valid = 1; b_wa = 9; b_wd = 32'h1234;
    #1;
    cmp("lit_haz1_9", haz1, 1'b1);
    cmp("lit_haz2_0", haz2, 1'b0);
    tick();
    idle_in(); ra1 = 9;
    #1;
    cmp("lit_wr9", rf_wa, 5'd9);
    cmp("lit_haz1_9_wb", haz1, 1'b1);
    tick();
    idle_in(); ra1 = 9;
    #1 cmp("lit_haz1_9_after", haz1, 1'b0);
    tick();

    // Starvation: forced stall in the 5th cycle after the push
    idle_in(); a_we = 1; a_wa = 3; a_wd = 32'hA; b_valid = 1; b_wa = 7; b_wd = 32'h77; tick();
    for (int k = 1; k <= 6; k++) begin
      idle_in(); a_we = 1; a_wa = 3; a_wd = k;
      #1;
      cmp("lit_starve_stall", stall_pipe, (k == 5));
      cmp("lit_starve_wa", rf_wa, (k == 5) ? 5'd7 : 5'd3);
      tick();
    end

    // FIFO fills; third request held until a slot frees
    idle_in(); a_we = 1; a_wa = 3; b_valid = 1; b_wa = 10; b_wd = 32'h10; tick();
    idle_in(); a_we = 1; a_wa = 3; b_valid = 1; b_wa = 11; b_wd = 32'h11; tick();
    for (int k = 2; k <= 6; k++) begin
      idle_in(); a_we = 1; a_wa = 3; b_valid = 1; b_wa = 12; b_wd = 32'h12;
      #1 cmp("lit_full_ready", b_ready, (k == 6));
      tick();
    end
    for (int k = 0; k < 3; k++) begin
      idle_in(); tick();
    end

    // Writes to r0 from both ports are dropped
    idle_in(); b_valid = 1; b_wa = 0; b_wd = 32'hFFFF; tick();
    idle_in(); a_we = 1; a_wa = 0; a_wd = 32'h5;
    #1 cmp("lit_r0_drop", rf_we, 1'b0);
    tick();
    idle_in();
    #1;
    cmp("lit_r0_empty_we", rf_we, 1'b0);
    cmp("lit_r0_ready", b_ready, 1'b1);
    tick();

    // Reset during a forced stall with both entries buffered
    idle_in(); a_we = 1; a_wa = 3; b_valid = 1; b_wa = 20; b_issue = 1; b_issue_wa = 12; ra1 = 12; tick();
    idle_in(); a_we = 1; a_wa = 3; b_valid = 1; b_wa = 21; ra1 = 12; tick();
    for (int k = 2; k <= 4; k++) begin
      idle_in(); a_we = 1; a_wa = 3; ra1 = 12; tick();
    end
    idle_in(); a_we = 1; a_wa = 3; ra1 = 12; ra2 = 12;
    #1;
    cmp("lit_pre_rst_stall", stall_pipe, 1'b1);
    cmp("lit_pre_rst_haz1", haz1, 1'b1);
    do_reset();
    for (int k = 0; k < 3; k++) begin
      idle_in(); ra1 = 12; tick();
    end

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      a_we       = ($urandom_range(0, 9) < 7);
      a_wa       = 5'($urandom_range(0, 7));
      a_wd       = $urandom;
      b_valid    = ($urandom_range(0, 9) < 4);
      b_wa       = 5'($urandom_range(0, 7));
      b_wd       = $urandom;
      b_issue    = ($urandom_range(0, 9) < 3);
      b_issue_wa = 5'($urandom_range(0, 7));
      ra1        = 5'($urandom_range(0, 7));
      ra2        = 5'($urandom_range(0, 7));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
